// File: rtl/regfile_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared definitions for the register-file controller:
//   - opcode encodings (3-bit op field carried with each handshake)
//   - controller state enumeration
//   - small decode helper used by the controller
// Optional build macro consumed by the controller: RFC_SATURATE_EN
// -----------------------------------------------------------------------------
package regfile_ctrl_pkg;

  // Opcode encodings
  localparam logic [2:0] OP_WRITE_SEQ  = 3'd0;
  localparam logic [2:0] OP_WRITE_ZERO = 3'd1;
  localparam logic [2:0] OP_READ_K     = 3'd2;
  localparam logic [2:0] OP_WRITE_K    = 3'd3;
  localparam logic [2:0] OP_ADD        = 3'd4;
  localparam logic [2:0] OP_SUB        = 3'd5;
  localparam logic [2:0] OP_AND        = 3'd6;
  localparam logic [2:0] OP_XOR        = 3'd7;

  // Controller states: IDLE accepts ops, ALU_EX is the single execute cycle
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ALU_EX = 1'b1
  } state_e;

  // All ALU opcodes live in the upper half of the encoding space
  function automatic logic isAluOp(input logic [2:0] opc);
    return opc[2];
  endfunction

endpackage : regfile_ctrl_pkg

// File: rtl/regfile_mem.sv
// -----------------------------------------------------------------------------
// regfile_mem
// DEPTH x DATA_W register storage (DEPTH = 2**ADDR_W).
//   clk      : clock, writes and clears on posedge
//   rst_n    : synchronous active-low reset, clears every entry
//   we       : write enable
//   waddr    : write address
//   wdata    : write data
//   raddrA   : read port A address  -> rdataA (combinational)
//   raddrB   : read port B address  -> rdataB (combinational)
// -----------------------------------------------------------------------------
module regfile_mem #(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddrA,
  output logic [DATA_W-1:0] rdataA,
  input  logic [ADDR_W-1:0] raddrB,
  output logic [DATA_W-1:0] rdataB
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] memR [DEPTH];

  // Storage update: reset clears all entries, otherwise single write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        memR[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      memR[waddr] <= wdata;
    end
  end

  // Two asynchronous read ports
  always_comb begin
    rdataA = memR[raddrA];
    rdataB = memR[raddrB];
  end

endmodule : regfile_mem

// File: rtl/regfile_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_fsm
// Register-file controller. Accepts one opcode per valid/ready handshake and
// performs sequential writes, indexed writes, indexed reads or two-cycle
// accumulator ALU ops (R0 <= R0 op Rk) on an internal register file.
//
// Ports:
//   clk            : clock
//   rst_n          : synchronous active-low reset
//   op_valid       : op/k/data_in valid this cycle
//   op_ready       : controller can accept (IDLE and not in reset)
//   op             : 3-bit opcode (see regfile_ctrl_pkg)
//   k              : index operand
//   data_in        : write data
//   data_out       : registered result / write echo
//   data_out_valid : one-cycle pulse when data_out updates
//   count_out      : sequential write pointer
//   ra / wa        : last read / write address
//   wr_en          : one-cycle pulse marking a register-file write
//   carry          : carry (ADD) / borrow (SUB) of the last add/sub
//   full           : sequential pointer status
//
// Build macro RFC_SATURATE_EN:
//   defined   - count_out saturates at DEPTH-1; full sticks once entry DEPTH-1
//               has been written sequentially; later WRITE_SEQ ops are
//               accepted but dropped.
//   undefined - count_out wraps; full pulses for the cycle after the wrap.
// -----------------------------------------------------------------------------
module regfile_ctrl_fsm
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] k,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic [ADDR_W-1:0] count_out,
  output logic [ADDR_W-1:0] ra,
  output logic [ADDR_W-1:0] wa,
  output logic              wr_en,
  output logic              carry,
  output logic              full
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  // Registered state and outputs
  state_e            stateR;
  logic [ADDR_W-1:0] countR, raR, waR;
  logic [DATA_W-1:0] dataOutR;
  logic              dataValidR, wrEnR, carryR, fullR;
  // Latched ALU operands and opcode
  logic [DATA_W-1:0] aR, bR;
  logic [2:0]        opR;

  // Next-state values
  state_e            stateNextS;
  logic [ADDR_W-1:0] countNextS, raNextS, waNextS;
  logic [DATA_W-1:0] dataOutNextS;
  logic              dataValidNextS, wrEnNextS, carryNextS, fullNextS;
  logic [DATA_W-1:0] aNextS, bNextS;
  logic [2:0]        opNextS;

  // Register-file port signals
  logic              memWeS;
  logic [ADDR_W-1:0] memWaddrS;
  logic [DATA_W-1:0] memWdataS;
  logic [DATA_W-1:0] rf0S, rfKS;

  // ALU datapath; bit DATA_W of sum/diff is carry/borrow
  logic [DATA_W:0]   sumS, diffS;
  logic              acceptS;

  regfile_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) uMem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (memWeS),
    .waddr  (memWaddrS),
    .wdata  (memWdataS),
    .raddrA (ADDR_ZERO),
    .rdataA (rf0S),
    .raddrB (k),
    .rdataB (rfKS)
  );

  // Handshake: ready only in IDLE and outside reset
  always_comb begin
    op_ready = (stateR == IDLE) && rst_n;
    acceptS  = op_valid && op_ready;
  end

  // ALU arithmetic on latched operands, one extra bit for carry/borrow
  always_comb begin
    sumS  = {1'b0, aR} + {1'b0, bR};
    diffS = {1'b0, aR} - {1'b0, bR};
  end

  // Next-state, register-file write and output decode
  always_comb begin
    stateNextS     = stateR;
    countNextS     = countR;
    raNextS        = raR;
    waNextS        = waR;
    dataOutNextS   = dataOutR;
    dataValidNextS = 1'b0;
    wrEnNextS      = 1'b0;
    carryNextS     = carryR;
    aNextS         = aR;
    bNextS         = bR;
    opNextS        = opR;
    memWeS         = 1'b0;
    memWaddrS      = countR;
    memWdataS      = data_in;
`ifdef RFC_SATURATE_EN
    fullNextS      = fullR;
`else
    // Wrap mode: full is a single-cycle pulse
    fullNextS      = 1'b0;
`endif

    case (stateR)
      IDLE: begin
        if (acceptS) begin
          if (isAluOp(op)) begin
            // Capture operands now; the write happens in ALU_EX
            raNextS    = k;
            aNextS     = rf0S;
            bNextS     = rfKS;
            opNextS    = op;
            stateNextS = ALU_EX;
          end else begin
            case (op)
              OP_WRITE_SEQ: begin
`ifdef RFC_SATURATE_EN
                if (!fullR) begin
                  memWeS         = 1'b1;
                  memWaddrS      = countR;
                  waNextS        = countR;
                  dataOutNextS   = data_in;
                  wrEnNextS      = 1'b1;
                  dataValidNextS = 1'b1;
                  if (countR == ADDR_MAX) begin
                    fullNextS = 1'b1;
                  end else begin
                    countNextS = countR + ADDR_ONE;
                  end
                end else begin
                  // Pointer exhausted: op is consumed with no effect
                  countNextS = countR;
                end
`else
                memWeS         = 1'b1;
                memWaddrS      = countR;
                waNextS        = countR;
                dataOutNextS   = data_in;
                wrEnNextS      = 1'b1;
                dataValidNextS = 1'b1;
                countNextS     = countR + ADDR_ONE;
                fullNextS      = (countR == ADDR_MAX);
`endif
              end
              OP_WRITE_ZERO: begin
                memWeS         = 1'b1;
                memWaddrS      = ADDR_ZERO;
                waNextS        = ADDR_ZERO;
                dataOutNextS   = data_in;
                wrEnNextS      = 1'b1;
                dataValidNextS = 1'b1;
              end
              OP_READ_K: begin
                raNextS        = k;
                waNextS        = ADDR_ZERO;
                dataOutNextS   = rfKS;
                dataValidNextS = 1'b1;
              end
              OP_WRITE_K: begin
                memWeS         = 1'b1;
                memWaddrS      = k;
                waNextS        = k;
                dataOutNextS   = data_in;
                wrEnNextS      = 1'b1;
                dataValidNextS = 1'b1;
              end
              default: begin
                stateNextS = IDLE;
              end
            endcase
          end
        end else begin
          stateNextS = IDLE;
        end
      end

      ALU_EX: begin
        case (opR)
          OP_ADD: begin
            memWdataS  = sumS[DATA_W-1:0];
            carryNextS = sumS[DATA_W];
          end
          OP_SUB: begin
            memWdataS  = diffS[DATA_W-1:0];
            carryNextS = diffS[DATA_W];
          end
          OP_AND: begin
            memWdataS = aR & bR;
          end
          OP_XOR: begin
            memWdataS = aR ^ bR;
          end
          default: begin
            memWdataS = aR;
          end
        endcase
        memWeS         = 1'b1;
        memWaddrS      = ADDR_ZERO;
        waNextS        = ADDR_ZERO;
        dataOutNextS   = memWdataS;
        wrEnNextS      = 1'b1;
        dataValidNextS = 1'b1;
        stateNextS     = IDLE;
      end

      default: begin
        stateNextS = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateR     <= IDLE;
      countR     <= ADDR_ZERO;
      raR        <= ADDR_ZERO;
      waR        <= ADDR_ZERO;
      dataOutR   <= {DATA_W{1'b0}};
      dataValidR <= 1'b0;
      wrEnR      <= 1'b0;
      carryR     <= 1'b0;
      fullR      <= 1'b0;
      aR         <= {DATA_W{1'b0}};
      bR         <= {DATA_W{1'b0}};
      opR        <= 3'd0;
    end else begin
      stateR     <= stateNextS;
      countR     <= countNextS;
      raR        <= raNextS;
      waR        <= waNextS;
      dataOutR   <= dataOutNextS;
      dataValidR <= dataValidNextS;
      wrEnR      <= wrEnNextS;
      carryR     <= carryNextS;
      fullR      <= fullNextS;
      aR         <= aNextS;
      bR         <= bNextS;
      opR        <= opNextS;
    end
  end

  // Output mapping
  always_comb begin
    data_out       = dataOutR;
    data_out_valid = dataValidR;
    count_out      = countR;
    ra             = raR;
    wa             = waR;
    wr_en          = wrEnR;
    carry          = carryR;
    full           = fullR;
  end

endmodule : regfile_ctrl_fsm

// File: doc/regfile_ctrl_fsm.md
Name: regfile_ctrl_fsm

Overview:
- Parametrised register-file controller: accepts one 3-bit opcode per handshake and performs sequential writes, indexed writes, indexed reads, or two-cycle accumulator ALU ops against an internal DEPTH x DATA_W register file.
- Successor to the fixed 5-bit/4-entry controller: adds width/depth parameters, valid/ready handshake, reset, ALU ops and a carry flag.
- Sits between the datapath sequencer and the register-file read/write ports.

Parameters:
- DATA_W, 5, data and register width in bits.
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- op_valid  in  1  opcode/operands valid this cycle.
- op_ready  out  1  controller can accept an op; equals (state==IDLE) && rst_n.
- op  in  3  opcode, see Behaviour.
- k  in  ADDR_W  index operand.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered result/echo.
- data_out_valid  out  1  one-cycle pulse when data_out is updated.
- count_out  out  ADDR_W  sequential write pointer.
- ra  out  ADDR_W  last read address.
- wa  out  ADDR_W  last write address.
- wr_en  out  1  one-cycle pulse marking a register-file write.
- carry  out  1  carry/borrow of last ADD/SUB.
- full  out  1  sequential pointer status (see Optional Feature).

Behaviour:
- Reset: state IDLE; count_out, ra, wa, data_out, carry, full = 0; data_out_valid and wr_en = 0; all register-file entries = 0. Reset taken in any state; an in-flight ALU op is discarded with no writeback.
- An op is accepted at a posedge where op_valid && op_ready. With no accept, data_out_valid and wr_en are 0 and all other outputs hold.
- States:
  - IDLE: accepts ops.
  - ALU_EX: one cycle, op_ready = 0, then returns to IDLE.
- Opcodes below are single-cycle unless noted. Effects are visible the cycle after the accept edge.
  - 000 WRITE_SEQ: rf[count_out] <= data_in; wa <= count_out; count_out <= count_out+1 (wraps DEPTH-1 -> 0); data_out <= data_in; wr_en and data_out_valid pulse.
  - 001 WRITE_ZERO: rf[0] <= data_in; wa <= 0; data_out <= data_in; wr_en and data_out_valid pulse.
  - 010 READ_K: ra <= k; data_out <= rf[k]; data_out_valid pulses; wa <= 0; no write.
  - 011 WRITE_K: rf[k] <= data_in; wa <= k; data_out <= data_in; wr_en and data_out_valid pulse.
  - 100 ADD, 101 SUB, 110 AND, 111 XOR (two-cycle):
    - Accept edge: ra <= k; latch a = rf[0], b = rf[k], op; go to ALU_EX.
    - ALU_EX edge: res = a op b, truncated to DATA_W; rf[0] <= res; wa <= 0; data_out <= res; wr_en and data_out_valid pulse; return to IDLE.
    - carry = bit DATA_W of a+b for ADD, and of a-b (borrow) for SUB; AND/XOR leave carry unchanged.
- k = 0 on an ALU op: both operands are rf[0] (e.g. XOR clears R0).
- Back-to-back ops: the next accept reads the register file after the previous write has committed; no forwarding is required.
- op/k/data_in are ignored while op_ready = 0.

Optional Feature:
- Macro RFC_SATURATE_EN.
- Defined: count_out saturates at DEPTH-1. full = 1 once a WRITE_SEQ has written entry DEPTH-1. Further WRITE_SEQ ops are accepted but perform no write, no wr_en and no data_out_valid. full clears only on reset.
- Undefined: count_out wraps, and full = 1 for exactly the cycle after count_out wraps to 0.

Decomposition:
- Package regfile_ctrl_pkg: opcode localparams (OP_WRITE_SEQ .. OP_XOR), state enum typedef (IDLE, ALU_EX).
- One sub-module, regfile_mem: DEPTH x DATA_W storage with synchronous reset clear, one write port and two combinational read ports.

Test Plan (DATA_W=5, ADDR_W=2):
- Reset, then 4x WRITE_SEQ with data 1,2,3,4 -> wa = 0,1,2,3; count_out 0->1->2->3->0; READ_K k=2 -> data_out = 3 with one data_out_valid pulse.
- WRITE_ZERO 30, WRITE_K k=1 data 5, ADD k=1 -> op_ready low 1 cycle; R0 = 3 (35 mod 32); carry = 1; wa = 0; ra = 1.
- R0=2, R3=4, SUB k=3 -> R0 = 30, carry (borrow) = 1; then XOR k=0 -> R0 = 0.
- ADD accepted, rst_n low in ALU_EX -> no write; all outputs and entries 0 next cycle; op_ready = 1 after rst_n high.
- op_valid held high through an ALU op with a WRITE_K queued behind it -> the write is accepted only on the first IDLE edge, exactly once.
- RFC_SATURATE_EN defined: 5x WRITE_SEQ -> fifth is dropped, count_out = 3, full = 1; undefined: fifth writes entry 0 and full pulses once after the wrap.
